axis_ad5791: RTL and testbench

- Four-channel serial driver for AD5791 20-bit DACs (X, Y, Z, U piezo axes).
- Sits downstream of axis_spm_control and takes its four 32-bit AXI-Stream position outputs.
- Streaming mode: continuously packs each sample into a 24-bit DAC-register write and shifts it out on four parallel SDIN lines with shared SCLK/SYNC.
- Configuration mode: holds streaming and transmits host-supplied 24-bit control words (per axis) on command.

---
 rtl/axis_ad5791_if.sv | 29 ++
 rtl/axis_ad5791.sv | 177 +++++++++++++++++
 tb/tb_axis_ad5791.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_ad5791_if.sv
// AXI-Stream sample and configuration inputs feeding the AD5791 driver.
interface axis_ad5791_if;
  logic [31:0] S_AXIS1_tdata;
  logic        S_AXIS1_tvalid;
  logic [31:0] S_AXIS2_tdata;
  logic        S_AXIS2_tvalid;
  logic [31:0] S_AXIS3_tdata;
  logic        S_AXIS3_tvalid;
  logic [31:0] S_AXIS4_tdata;
  logic        S_AXIS4_tvalid;
  logic [31:0] S_AXISCFG_tdata;
  logic        S_AXISCFG_tvalid;

  modport master (
    output S_AXIS1_tdata, S_AXIS1_tvalid,
    output S_AXIS2_tdata, S_AXIS2_tvalid,
    output S_AXIS3_tdata, S_AXIS3_tvalid,
    output S_AXIS4_tdata, S_AXIS4_tvalid,
    output S_AXISCFG_tdata, S_AXISCFG_tvalid
  );

  modport slave (
    input S_AXIS1_tdata, S_AXIS1_tvalid,
    input S_AXIS2_tdata, S_AXIS2_tvalid,
    input S_AXIS3_tdata, S_AXIS3_tvalid,
    input S_AXIS4_tdata, S_AXIS4_tvalid,
    input S_AXISCFG_tdata, S_AXISCFG_tvalid
  );
endinterface

// File: rtl/axis_ad5791.sv
// Four-channel AD5791 serial driver: streams X/Y/Z/U samples as DAC-register
// writes on parallel SDIN lines with shared SCLK/SYNC/LDAC, or sends
// host-supplied 24-bit control words in configuration mode.
module axis_ad5791 #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned DATA_MSB   = 31
) (
  input  logic                a_clk,
  input  logic                reset,
  axis_ad5791_if.slave        s_axis,
  input  logic                configuration_mode,
  input  logic [2:0]          configuration_axis,
  input  logic                configuration_send,
  output logic                dac_sclk,
  output logic                dac_sync_n,
  output logic [3:0]          dac_sdin,
  output logic                dac_ldac_n,
  output logic                busy
);

  localparam int unsigned DATA_W       = 20;
  localparam int unsigned WORD_W       = 24;
  localparam int unsigned N_AXES       = 4;
  localparam int unsigned SHIFT_CYCLES = 2 * WORD_W;
  localparam int unsigned CNT_MAX      = (GAP_CYCLES > SHIFT_CYCLES) ? GAP_CYCLES : SHIFT_CYCLES;
  localparam int unsigned CNT_W        = $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, LDAC} state_t;

  logic [N_AXES-1:0][31:0]       tdata;
  logic [N_AXES-1:0]             tvalid;
  logic [N_AXES-1:0][DATA_W-1:0] sample_reg;
  logic [N_AXES-1:0][DATA_W-1:0] new_data;
  logic [N_AXES-1:0][WORD_W-1:0] stream_word;
  logic [N_AXES-1:0][WORD_W-1:0] cfg_reg;
  logic [N_AXES-1:0][WORD_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  state_t                        state, state_nxt;
  logic                          is_stream, stream_nxt;
  logic                          send_d, pending, start_cfg, go_idle;
  logic                          sclk_nxt, sync_n_nxt, ldac_n_nxt, busy_nxt;
  logic [N_AXES-1:0]             sdin_nxt;
  logic                          unused_bits;

  assign tdata  = {s_axis.S_AXIS4_tdata, s_axis.S_AXIS3_tdata,
                   s_axis.S_AXIS2_tdata, s_axis.S_AXIS1_tdata};
  assign tvalid = {s_axis.S_AXIS4_tvalid, s_axis.S_AXIS3_tvalid,
                   s_axis.S_AXIS2_tvalid, s_axis.S_AXIS1_tvalid};

  // Bits outside the DAC slices are intentionally dropped.
  assign unused_bits = ^{tdata, s_axis.S_AXISCFG_tdata[31:WORD_W]};

  // DAC-register write words, using this cycle's sample when it is valid.
  always_comb begin
    for (int n = 0; n < N_AXES; n++) begin
      new_data[n]    = tdata[n][DATA_MSB -: DATA_W];
      stream_word[n] = {1'b0, 3'b001, (tvalid[n] ? new_data[n] : sample_reg[n])};
    end
  end

  // Per-axis sample holding registers, loaded whenever tvalid is high.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      sample_reg <= '0;
    end else begin
      for (int n = 0; n < N_AXES; n++) begin
        if (tvalid[n]) sample_reg[n] <= new_data[n];
      end
    end
  end

  // Per-axis control words written by the host in configuration mode.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      cfg_reg <= '0;
    end else if (configuration_mode && s_axis.S_AXISCFG_tvalid && !configuration_axis[2]) begin
      cfg_reg[configuration_axis[1:0]] <= s_axis.S_AXISCFG_tdata[WORD_W-1:0];
    end
  end

  // Send rising-edge detector; the request stays pending until a config frame starts.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      send_d  <= 1'b0;
      pending <= 1'b0;
    end else begin
      send_d <= configuration_send;
      if (!configuration_mode) pending <= 1'b0;
      else pending <= (pending && !start_cfg) || (configuration_send && !send_d);
    end
  end

  // Frame sequencing. The cycle that would return to IDLE also makes the IDLE
  // start decision, so back-to-back frames run at the minimum period.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shreg_nxt  = shreg;
    stream_nxt = is_stream;
    go_idle    = 1'b0;
    start_cfg  = 1'b0;
    case (state)
      IDLE: go_idle = 1'b1;
      SHIFT: begin
        if (cnt == CNT_W'(SHIFT_CYCLES - 1)) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt[0]) begin
            for (int n = 0; n < N_AXES; n++) shreg_nxt[n] = {shreg[n][WORD_W-2:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_nxt = '0;
          if (is_stream) state_nxt = LDAC;
          else go_idle = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LDAC: go_idle = 1'b1;
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      if (configuration_mode && pending) begin
        state_nxt  = SHIFT;
        shreg_nxt  = cfg_reg;
        stream_nxt = 1'b0;
        start_cfg  = 1'b1;
      end else if (!configuration_mode && (|tvalid)) begin
        state_nxt  = SHIFT;
        shreg_nxt  = stream_word;
        stream_nxt = 1'b1;
      end
    end

    sclk_nxt   = (state_nxt == SHIFT) && !cnt_nxt[0];
    sync_n_nxt = (state_nxt != SHIFT);
    ldac_n_nxt = (state_nxt != LDAC);
    busy_nxt   = (state_nxt != IDLE);
    for (int n = 0; n < N_AXES; n++) begin
      sdin_nxt[n] = (state_nxt == SHIFT) && shreg_nxt[n][WORD_W-1];
    end
  end

  // State, shift data and registered DAC pins.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      is_stream  <= 1'b0;
      dac_sclk   <= 1'b0;
      dac_sync_n <= 1'b1;
      dac_sdin   <= '0;
      dac_ldac_n <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      is_stream  <= stream_nxt;
      dac_sclk   <= sclk_nxt;
      dac_sync_n <= sync_n_nxt;
      dac_sdin   <= sdin_nxt;
      dac_ldac_n <= ldac_n_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_axis_ad5791.sv
// Directed self-checking bench for axis_ad5791: config frames, streaming,
// back-to-back period, negative samples, busy-time send, mid-frame reset.
module tb_axis_ad5791;
  localparam int unsigned GAP = 4;

  logic       a_clk = 1'b0;
  logic       reset;
  logic       configuration_mode;
  logic [2:0] configuration_axis;
  logic       configuration_send;
  logic       dac_sclk, dac_sync_n, dac_ldac_n, busy;
  logic [3:0] dac_sdin;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  axis_ad5791_if bus ();

  axis_ad5791 #(.GAP_CYCLES(GAP), .DATA_MSB(31)) dut (
    .a_clk(a_clk),
    .reset(reset),
    .s_axis(bus),
    .configuration_mode(configuration_mode),
    .configuration_axis(configuration_axis),
    .configuration_send(configuration_send),
    .dac_sclk(dac_sclk),
    .dac_sync_n(dac_sync_n),
    .dac_sdin(dac_sdin),
    .dac_ldac_n(dac_ldac_n),
    .busy(busy)
  );

  always #5 a_clk = ~a_clk;
  always @(posedge a_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; waits for SYNC low and records one frame.
  // Returns at the negedge of the first cycle after SYNC rises.
  task automatic capture(output logic [3:0][23:0] w, output int low, output int falls,
                         output int start, output logic ok);
    int   waited;
    logic prev;
    w = '0; low = 0; falls = 0; start = 0; ok = 1'b0; waited = 0;
    while (dac_sync_n && waited < 300) begin
      @(negedge a_clk);
      waited++;
    end
    if (dac_sync_n) return;
    ok    = 1'b1;
    start = cyc;
    prev  = 1'b0;
    while (!dac_sync_n && low < 100) begin
      if (dac_sclk) for (int n = 0; n < 4; n++) w[n] = {w[n][22:0], dac_sdin[n]};
      if (prev && !dac_sclk) falls++;
      prev = dac_sclk;
      low++;
      @(negedge a_clk);
    end
  endtask

  task automatic count_sync_low(input int ncyc, output int lows);
    lows = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge a_clk);
      if (!dac_sync_n) lows++;
    end
  endtask

  initial begin
    logic [3:0][23:0] w;
    int low, falls, start_a, start_b, lows, waited;
    logic ok;

    reset = 1'b1;
    configuration_mode = 1'b1;
    configuration_axis = 3'd0;
    configuration_send = 1'b0;
    bus.S_AXIS1_tdata = '0; bus.S_AXIS1_tvalid = 1'b0;
    bus.S_AXIS2_tdata = '0; bus.S_AXIS2_tvalid = 1'b0;
    bus.S_AXIS3_tdata = '0; bus.S_AXIS3_tvalid = 1'b0;
    bus.S_AXIS4_tdata = '0; bus.S_AXIS4_tvalid = 1'b0;
    bus.S_AXISCFG_tdata = '0; bus.S_AXISCFG_tvalid = 1'b0;

    // Reset values.
    repeat (3) @(negedge a_clk);
    check("rst_outputs", {27'd0, dac_sclk, dac_sync_n, dac_ldac_n, busy, 1'b0},
          {27'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("rst_sdin", 32'(dac_sdin), 32'h0);
    reset = 1'b0;

    // Idle in config mode without a send edge.
    count_sync_low(20, lows);
    check("idle_no_frame", 32'(lows), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Load config words; axis 4 must be ignored.
    bus.S_AXISCFG_tvalid = 1'b1;
    configuration_axis = 3'd3; bus.S_AXISCFG_tdata = 32'd128; @(negedge a_clk);
    configuration_axis = 3'd2; bus.S_AXISCFG_tdata = 32'd64;  @(negedge a_clk);
    configuration_axis = 3'd1; bus.S_AXISCFG_tdata = 32'd32;  @(negedge a_clk);
    configuration_axis = 3'd0; bus.S_AXISCFG_tdata = 32'd16;  @(negedge a_clk);
    configuration_axis = 3'd4; bus.S_AXISCFG_tdata = 32'h00FF_FFFF; @(negedge a_clk);
    bus.S_AXISCFG_tvalid = 1'b0;
    configuration_send = 1'b1;

    capture(w, low, falls, start_a, ok);
    check("cfg_started", 32'(ok), 32'd1);
    check("cfg_sync_low", 32'(low), 32'd48);
    check("cfg_sclk_falls", 32'(falls), 32'd24);
    check("cfg_word0", 32'(w[0]), 32'h000010);
    check("cfg_word1", 32'(w[1]), 32'h000020);
    check("cfg_word2", 32'(w[2]), 32'h000040);
    check("cfg_word3", 32'(w[3]), 32'h000080);
    check("cfg_gap_pins", {28'd0, dac_sync_n, dac_sclk, busy, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    check("cfg_gap_sdin", 32'(dac_sdin), 32'h0);
    for (int i = 0; i < int'(GAP); i++) begin
      check("cfg_no_ldac", 32'(dac_ldac_n), 32'd1);
      @(negedge a_clk);
    end
    check("cfg_end_ldac", 32'(dac_ldac_n), 32'd1);
    check("cfg_end_busy", 32'(busy), 32'd0);
    count_sync_low(100, lows);
    check("cfg_no_retrigger", 32'(lows), 32'd0);
    configuration_send = 1'b0;

    // Streaming axis X with tvalid held.
    configuration_mode = 1'b0;
    bus.S_AXIS1_tdata = 32'h0000_1000; bus.S_AXIS1_tvalid = 1'b1;
    capture(w, low, falls, start_a, ok);
    check("strA_started", 32'(ok), 32'd1);
    check("strA_sync_low", 32'(low), 32'd48);
    check("strA_sclk_falls", 32'(falls), 32'd24);
    check("strA_word0", 32'(w[0]), 32'h100001);
    check("strA_word1", 32'(w[1]), 32'h100000);
    check("strA_word3", 32'(w[3]), 32'h100000);
    bus.S_AXIS1_tdata = 32'h0000_2000;
    repeat (GAP) @(negedge a_clk);
    check("strA_ldac", 32'(dac_ldac_n), 32'd0);
    check("strA_ldac_busy", {30'd0, busy, dac_sync_n}, {30'd0, 1'b1, 1'b1});
    capture(w, low, falls, start_b, ok);
    check("strB_started", 32'(ok), 32'd1);
    check("strB_period", 32'(start_b - start_a), 32'(48 + GAP + 1));
    check("strB_word0", 32'(w[0]), 32'h100002);
    check("strB_word2", 32'(w[2]), 32'h100000);

    // Negative sample on axis Y only; X keeps its last sample.
    bus.S_AXIS1_tvalid = 1'b0;
    bus.S_AXIS2_tdata = -32'sd4096; bus.S_AXIS2_tvalid = 1'b1;
    repeat (GAP) @(negedge a_clk);
    check("strB_ldac", 32'(dac_ldac_n), 32'd0);
    capture(w, low, falls, start_a, ok);
    check("neg_started", 32'(ok), 32'd1);
    check("neg_word0", 32'(w[0]), 32'h100002);
    check("neg_word1", 32'(w[1]), 32'h1FFFFF);
    check("neg_word2", 32'(w[2]), 32'h100000);
    check("neg_word3", 32'(w[3]), 32'h100000);

    // Send edge while a stream frame is in flight.
    repeat (GAP + 1) @(negedge a_clk);
    check("busy_frame_sync", 32'(dac_sync_n), 32'd0);
    repeat (10) @(negedge a_clk);
    configuration_mode = 1'b1; configuration_send = 1'b1; bus.S_AXIS2_tvalid = 1'b0;
    waited = 0;
    while (!dac_sync_n && waited < 100) begin
      @(negedge a_clk);
      waited++;
    end
    check("busy_frame_done", 32'(dac_sync_n), 32'd1);
    repeat (GAP) @(negedge a_clk);
    check("busy_frame_ldac", 32'(dac_ldac_n), 32'd0);
    capture(w, low, falls, start_a, ok);
    check("late_cfg_started", 32'(ok), 32'd1);
    check("late_cfg_word0", 32'(w[0]), 32'h000010);
    check("late_cfg_word3", 32'(w[3]), 32'h000080);
    repeat (GAP) @(negedge a_clk);
    check("late_cfg_no_ldac", 32'(dac_ldac_n), 32'd1);
    check("late_cfg_idle", 32'(busy), 32'd0);
    configuration_send = 1'b0;

    // Reset at frame cycle 20 with a send pending.
    configuration_mode = 1'b0;
    bus.S_AXIS1_tvalid = 1'b1;
    waited = 0;
    while (dac_sync_n && waited < 100) begin
      @(negedge a_clk);
      waited++;
    end
    check("rf_started", 32'(dac_sync_n), 32'd0);
    bus.S_AXIS1_tvalid = 1'b0;
    configuration_mode = 1'b1; configuration_send = 1'b1;
    repeat (20) @(negedge a_clk);
    check("rf_cycle20", {30'd0, dac_sync_n, dac_sclk}, {30'd0, 1'b0, 1'b1});
    reset = 1'b1; configuration_send = 1'b0;
    @(negedge a_clk);
    check("rf_pins", {28'd0, dac_sync_n, dac_sclk, busy, dac_ldac_n}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    check("rf_sdin", 32'(dac_sdin), 32'h0);
    reset = 1'b0;
    count_sync_low(80, lows);
    check("rf_pending_cleared", 32'(lows), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
